fft_frame_sequencer: RTL and testbench

Frame-level controller that sits beside the FFT block and sequences one spectrum capture at a time: arms time-sample acquisition, waits for the 1024-sample time buffer to fill, gates exactly one aligned 1024-bin frequency frame into the display memory, then holds that frame for a programmable period before re-arming. It replaces the free-running behaviour so the display sees whole, non-torn frames, and it supports continuous and single-shot modes.

---
 rtl/fft_frame_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//
// Purpose:
//   Frame-level controller beside the FFT block. It captures one spectrum at
//   a time. It arms time-sample acquisition and waits for the 1024-sample
//   time buffer to fill. It then gates exactly one aligned 1024-bin frequency
//   frame into the display memory. Finally it holds that frame for a
//   programmable period before re-arming. Continuous (run) and single-shot
//   (single) modes are supported.
//
// Build option:
//   FFT_SEQ_TIMEOUT_EN - when defined, a 24-bit acquisition watchdog is built.
//   It counts cycles spent in ACQ_HI+ACQ_LO. On reaching TIMEOUT_CYCLES it
//   sets the sticky flgTimeout and re-arms. When undefined, flgTimeout is
//   tied 0 and acquisition waits indefinitely.
//
// Ports:
//   ckaTime             in   clock, rising edge
//   aresetn             in   synchronous active-low reset
//   run                 in   1 = continuous capture, 0 = stop after frame
//   single              in   one-cycle request for a single frame
//   enaTime             in   FFT time-RAM enable (high while filling)
//   flgFreqSampleValid  in   FFT output sample valid
//   addrFreq[9:0]       in   FFT output bin index, 0 = frame start
//   dispBusy            in   display mid-scan; defers re-arm
//   flgStartAcquisition out  one-cycle acquisition restart pulse
//   weFreq              out  frequency RAM write enable
//   flgFrameReady       out  frame complete, held until next re-arm
//   flgTimeout          out  sticky watchdog flag
//   stateDbg[2:0]       out  current state code
//   cntFrames[15:0]     out  completed frame count (wraps)

module fft_frame_sequencer #(
    parameter logic [23:0] HOLD_CYCLES    = 24'd1_000_000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4_194_304
) (
    input  logic        ckaTime,
    input  logic        aresetn,
    input  logic        run,
    input  logic        single,
    input  logic        enaTime,
    input  logic        flgFreqSampleValid,
    input  logic [9:0]  addrFreq,
    input  logic        dispBusy,
    output logic        flgStartAcquisition,
    output logic        weFreq,
    output logic        flgFrameReady,
    output logic        flgTimeout,
    output logic [2:0]  stateDbg,
    output logic [15:0] cntFrames
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        ACQ_HI = 3'd2,
        ACQ_LO = 3'd3,
        SYNC   = 3'd4,
        XFER   = 3'd5,
        HOLD   = 3'd6
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [10:0] bin_cnt;
    logic [23:0] hold_cnt;
    logic        single_pend;
    logic        frame_start;
    logic        frame_done;
    logic        timeout_hit;

    assign frame_start = flgFreqSampleValid && (addrFreq == 10'd0);
    assign stateDbg    = state;

`ifdef FFT_SEQ_TIMEOUT_EN
    logic [23:0] wd_cnt;

    // Watchdog: counts acquisition cycles. Every ARM gives a retry a fresh
    // budget. The flag stays set until reset.
    always_ff @(posedge ckaTime) begin
        if (!aresetn) begin
            wd_cnt     <= 24'd0;
            flgTimeout <= 1'b0;
        end else begin
            if (state == ARM)
                wd_cnt <= 24'd0;
            else if ((state == ACQ_HI || state == ACQ_LO) && !timeout_hit)
                wd_cnt <= wd_cnt + 24'd1;
            if (timeout_hit)
                flgTimeout <= 1'b1;
        end
    end

    assign timeout_hit = (state == ACQ_HI || state == ACQ_LO) &&
                         (wd_cnt == TIMEOUT_CYCLES - 24'd1);
`else
    // The parameter is kept so both builds share one interface.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
    assign flgTimeout     = 1'b0;
`endif

    // State register.
    always_ff @(posedge ckaTime) begin
        if (!aresetn)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic. A frame completes on the 1024th valid bin that is not
    // itself a restart (addrFreq = 0). A watchdog expiry overrides the
    // acquisition waits.
    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        case (state)
            IDLE:    if (run || single || single_pend) state_next = ARM;
            ARM:     state_next = ACQ_HI;
            ACQ_HI:  if (enaTime) state_next = ACQ_LO;
            ACQ_LO:  if (!enaTime) state_next = SYNC;
            SYNC:    if (frame_start) state_next = XFER;
            XFER: begin
                if (flgFreqSampleValid && (addrFreq != 10'd0) &&
                    (bin_cnt == 11'd1023)) begin
                    frame_done = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if ((hold_cnt == 24'd0) && !dispBusy)
                    state_next = (run || single_pend || single) ? ARM : IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (timeout_hit)
            state_next = ARM;
    end

    // Registered outputs and counters. A single request is remembered until
    // the FSM next enters ARM. The ready flag survives IDLE and clears only
    // when a new capture is armed.
    always_ff @(posedge ckaTime) begin
        if (!aresetn) begin
            flgStartAcquisition <= 1'b0;
            weFreq              <= 1'b0;
            flgFrameReady       <= 1'b0;
            cntFrames           <= 16'd0;
            bin_cnt             <= 11'd0;
            hold_cnt            <= 24'd0;
            single_pend         <= 1'b0;
        end else begin
            flgStartAcquisition <= (state == ARM);
            weFreq <= ((state == SYNC) && frame_start) ||
                      ((state == XFER) && flgFreqSampleValid);

            if ((state == SYNC) && frame_start)
                bin_cnt <= 11'd1;
            else if ((state == XFER) && flgFreqSampleValid) begin
                if (addrFreq == 10'd0)
                    bin_cnt <= 11'd1;
                else if (frame_done)
                    bin_cnt <= 11'd0;
                else
                    bin_cnt <= bin_cnt + 11'd1;
            end

            if (frame_done) begin
                cntFrames     <= cntFrames + 16'd1;
                flgFrameReady <= 1'b1;
                hold_cnt      <= HOLD_CYCLES - 24'd1;
            end else if ((state == HOLD) && (hold_cnt != 24'd0)) begin
                hold_cnt <= hold_cnt - 24'd1;
            end

            if (state_next == ARM) begin
                flgFrameReady <= 1'b0;
                single_pend   <= 1'b0;
            end else if (single) begin
                single_pend   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer
//
// Purpose:
//   Directed bench for fft_frame_sequencer. It uses a short hold period so
//   that whole frames fit in a short run. The FFT side is driven by hand:
//   enaTime is held high for 1024 cycles, then bin streams are sent. Each
//   stream can start at any bin index.
//
// Ports: none (top-level bench).

module tb_fft_frame_sequencer;

    localparam logic [23:0] HOLD    = 24'd20;
    localparam logic [23:0] TIMEOUT = 24'd1000;

    logic        ckaTime = 1'b0;
    logic        aresetn;
    logic        run;
    logic        single;
    logic        enaTime;
    logic        flgFreqSampleValid;
    logic [9:0]  addrFreq;
    logic        dispBusy;
    logic        flgStartAcquisition;
    logic        weFreq;
    logic        flgFrameReady;
    logic        flgTimeout;
    logic [2:0]  stateDbg;
    logic [15:0] cntFrames;

    int total = 0;
    int bad   = 0;
    int wr;
    int steps;
    int pulses;

    fft_frame_sequencer #(
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .ckaTime            (ckaTime),
        .aresetn            (aresetn),
        .run                (run),
        .single             (single),
        .enaTime            (enaTime),
        .flgFreqSampleValid (flgFreqSampleValid),
        .addrFreq           (addrFreq),
        .dispBusy           (dispBusy),
        .flgStartAcquisition(flgStartAcquisition),
        .weFreq             (weFreq),
        .flgFrameReady      (flgFrameReady),
        .flgTimeout         (flgTimeout),
        .stateDbg           (stateDbg),
        .cntFrames          (cntFrames)
    );

    always #5 ckaTime = ~ckaTime;

    // One comparison: counts it, and reports and counts any failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive the FFT-side inputs, then advance to the next falling edge,
    // where outputs are sampled.
    task automatic applyStimulus(input logic v, input logic [9:0] a,
                                 input logic e);
        flgFreqSampleValid = v;
        addrFreq           = a;
        enaTime            = e;
        @(negedge ckaTime);
    endtask

    // Step until the acquisition pulse appears. Returns -1 if the limit
    // expires first.
    task automatic waitStart(input logic e, input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            applyStimulus(1'b0, 10'd0, e);
            if (flgStartAcquisition) begin
                n = k;
                break;
            end
        end
    endtask

    // Buffer-reset acknowledge, 1024 filling cycles, then the buffer is full.
    task automatic acquire();
        for (int i = 0; i < 1024; i++)
            applyStimulus(1'b0, 10'd0, 1'b1);
        applyStimulus(1'b0, 10'd0, 1'b0);
    endtask

    // Send n valid bins starting at index start, counting write enables.
    task automatic streamBins(input int start, input int n, inout int cnt);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 10'((start + i) % 1024), 1'b0);
            if (weFreq) cnt++;
        end
    endtask

    initial begin
        aresetn = 1'b0; run = 1'b1; single = 1'b0; dispBusy = 1'b0;
        enaTime = 1'b0; flgFreqSampleValid = 1'b0; addrFreq = 10'd0;
        repeat (3) @(negedge ckaTime);
        checkOutput("rst_start", flgStartAcquisition, 0);
        checkOutput("rst_we",    weFreq, 0);
        checkOutput("rst_ready", flgFrameReady, 0);
        checkOutput("rst_tout",  flgTimeout, 0);
        checkOutput("rst_state", stateDbg, 0);
        checkOutput("rst_cnt",   cntFrames, 0);

        // Release: ARM after one edge, pulse after the second edge.
        aresetn = 1'b1;
        applyStimulus(1'b0, 10'd0, 1'b0);
        checkOutput("arm_state", stateDbg, 1);
        checkOutput("arm_nopulse", flgStartAcquisition, 0);
        applyStimulus(1'b0, 10'd0, 1'b0);
        checkOutput("pulse_c2", flgStartAcquisition, 1);
        checkOutput("acqhi_state", stateDbg, 2);
        applyStimulus(1'b0, 10'd0, 1'b0);
        checkOutput("pulse_end", flgStartAcquisition, 0);

        // Frame 1: aligned stream.
        acquire();
        checkOutput("sync_state", stateDbg, 4);
        wr = 0;
        streamBins(0, 1024, wr);
        checkOutput("f1_writes", wr, 1024);
        checkOutput("f1_cnt", cntFrames, 1);
        checkOutput("f1_ready", flgFrameReady, 1);
        checkOutput("f1_hold", stateDbg, 6);
        waitStart(1'b0, 5000, steps);
        checkOutput("f1_gap", steps, int'(HOLD) + 1);
        checkOutput("f1_ready_clr", flgFrameReady, 0);

        // Frame 2: stream begins mid-frame at bin 517.
        acquire();
        wr = 0;
        streamBins(517, 507, wr);
        checkOutput("f2_prealign_writes", wr, 0);
        checkOutput("f2_still_sync", stateDbg, 4);
        streamBins(0, 1024, wr);
        checkOutput("f2_writes", wr, 1024);
        checkOutput("f2_cnt", cntFrames, 2);
        waitStart(1'b0, 5000, steps);
        checkOutput("f2_gap", steps, int'(HOLD) + 1);

        // Frame 3: restart after 100 bins, and run drops mid-frame.
        acquire();
        wr = 0;
        streamBins(0, 100, wr);
        streamBins(0, 1000, wr);
        checkOutput("f3_no_early", cntFrames, 2);
        checkOutput("f3_xfer", stateDbg, 5);
        run = 1'b0;
        streamBins(1000, 24, wr);
        checkOutput("f3_writes", wr, 1124);
        checkOutput("f3_cnt", cntFrames, 3);
        steps = -1;
        for (int k = 1; k <= 200; k++) begin
            applyStimulus(1'b0, 10'd0, 1'b0);
            if (stateDbg == 3'd0) begin
                steps = k;
                break;
            end
        end
        checkOutput("f3_hold_len", steps, int'(HOLD));
        checkOutput("f3_idle_ready", flgFrameReady, 1);
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            applyStimulus(1'b0, 10'd0, 1'b0);
            if (flgStartAcquisition) pulses++;
        end
        checkOutput("idle_no_arm", pulses, 0);

        // Single shot from IDLE; a second single is latched during ACQ.
        single = 1'b1;
        applyStimulus(1'b0, 10'd0, 1'b0);
        single = 1'b0;
        checkOutput("single_arm", stateDbg, 1);
        applyStimulus(1'b0, 10'd0, 1'b0);
        checkOutput("single_pulse", flgStartAcquisition, 1);
        checkOutput("single_ready_clr", flgFrameReady, 0);
        single = 1'b1;
        applyStimulus(1'b0, 10'd0, 1'b0);
        single = 1'b0;
        acquire();
        wr = 0;
        streamBins(0, 1024, wr);
        checkOutput("f4_writes", wr, 1024);
        checkOutput("f4_cnt", cntFrames, 4);

        // The latched single re-arms. dispBusy defers the re-arm by 500 cycles.
        steps = -1;
        for (int k = 1; k <= 2000; k++) begin
            dispBusy = (k < int'(HOLD) + 500);
            applyStimulus(1'b0, 10'd0, 1'b0);
            if (flgStartAcquisition) begin
                steps = k;
                break;
            end
        end
        dispBusy = 1'b0;
        checkOutput("busy_gap", steps, int'(HOLD) + 501);

        // Acquisition stall with enaTime stuck high.
        waitStart(1'b1, 1200, steps);
`ifdef FFT_SEQ_TIMEOUT_EN
        checkOutput("tout_retry", steps, int'(TIMEOUT) + 1);
        checkOutput("tout_flag", flgTimeout, 1);
`else
        checkOutput("tout_none", steps, -1);
        checkOutput("tout_flag", flgTimeout, 0);
        checkOutput("tout_waiting", stateDbg, 3);
`endif

        // Reset in the middle of operation.
        aresetn = 1'b0;
        applyStimulus(1'b0, 10'd0, 1'b0);
        checkOutput("rst2_state", stateDbg, 0);
        checkOutput("rst2_cnt", cntFrames, 0);
        checkOutput("rst2_tout", flgTimeout, 0);
        checkOutput("rst2_start", flgStartAcquisition, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
